axis_stim_gen_mc: RTL

//  Parametrised multi-channel AXI4-Stream stimulus source; successor to the single-channel stim block.

---
 rtl/axis_stim_gen_mc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/axis_stim_gen_mc.sv
// axis_stim_gen_mc: multi-channel AXI4-Stream stimulus source.
// Emits packets with a selectable data pattern; tdest steps round-robin
// over NUM_CH channels, one step per packet. Config is latched at start.
// Optional feature: define AXIS_STIM_GAP_EN to add the gap_cycles port and
// an idle GAP state between packets.
module axis_stim_gen_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 4,
  parameter int NUM_CH     = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic [LEN_WIDTH-1:0]    num_pkts,
`ifdef AXIS_STIM_GAP_EN
  input  logic [7:0]              gap_cycles,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DEST_WIDTH-1:0]   M_AXIS_tdest,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tlast,
  input  logic                    M_AXIS_tready,
  output logic                    M_AXIS_tvalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef AXIS_STIM_GAP_EN
    S_GAP  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;      // effective length, never 0
  logic [LEN_WIDTH-1:0]  npkts_q, npkts_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;    // beat within packet
  logic [LEN_WIDTH-1:0]  pkt_q, pkt_d;      // packet index within run
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [31:0]           gbeat_q, gbeat_d;  // run-global beat counter
  logic [31:0]           lfsr_q, lfsr_d;
  logic                  stop_q, stop_d;    // sticky stop request
`ifdef AXIS_STIM_GAP_EN
  logic [7:0]            gap_q, gap_d;
  logic [7:0]            gcnt_q, gcnt_d;
`endif

  logic hs, is_last, last_pkt;

  // Galois LFSR, x^32+x^22+x^2+x+1, shifting toward the MSB
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {s[30:0], 1'b0} ^ (s[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  assign M_AXIS_tvalid = (state_q == S_SEND);
  assign is_last       = (beat_q == len_q - LEN_WIDTH'(1));
  assign last_pkt      = (npkts_q != '0) && (pkt_q == npkts_q - LEN_WIDTH'(1));
  assign hs            = M_AXIS_tvalid && M_AXIS_tready;

  // Next-state: run control, counters and pattern generators
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    npkts_d = npkts_q;
    beat_d  = beat_q;
    pkt_d   = pkt_q;
    dest_d  = dest_q;
    gbeat_d = gbeat_q;
    lfsr_d  = lfsr_q;
    stop_d  = stop_q;
`ifdef AXIS_STIM_GAP_EN
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // a stop arriving with start is dropped: the run starts clean
        if (start) begin
          state_d = S_SEND;
          mode_d  = mode;
          len_d   = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
          npkts_d = num_pkts;
          beat_d  = '0;
          pkt_d   = '0;
          dest_d  = '0;
          gbeat_d = '0;
          lfsr_d  = 32'h0000_0001;
          stop_d  = 1'b0;
`ifdef AXIS_STIM_GAP_EN
          gap_d   = gap_cycles;
`endif
        end
      end
      S_SEND: begin
        if (stop) stop_d = 1'b1;
        if (hs) begin
          gbeat_d = gbeat_q + 32'd1;
          lfsr_d  = lfsr_step(lfsr_q);
          if (is_last) begin
            beat_d = '0;
            if (last_pkt || stop_q || stop) begin
              state_d = S_DONE;
            end else begin
              pkt_d  = pkt_q + LEN_WIDTH'(1);
              dest_d = (dest_q == DEST_WIDTH'(NUM_CH - 1)) ? '0 : dest_q + DEST_WIDTH'(1);
`ifdef AXIS_STIM_GAP_EN
              if (gap_q != 8'd0) begin
                state_d = S_GAP;
                gcnt_d  = gap_q;
              end
`endif
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
      end
`ifdef AXIS_STIM_GAP_EN
      S_GAP: begin
        // one idle cycle per count; a stop here ends the run at once
        if (stop || stop_q)      state_d = S_DONE;
        else if (gcnt_q <= 8'd1) state_d = S_SEND;
        else                     gcnt_d  = gcnt_q - 8'd1;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      len_q   <= LEN_WIDTH'(1);
      npkts_q <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      dest_q  <= '0;
      gbeat_q <= '0;
      lfsr_q  <= 32'h0000_0001;
      stop_q  <= 1'b0;
`ifdef AXIS_STIM_GAP_EN
      gap_q   <= 8'd0;
      gcnt_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      npkts_q <= npkts_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      dest_q  <= dest_d;
      gbeat_q <= gbeat_d;
      lfsr_q  <= lfsr_d;
      stop_q  <= stop_d;
`ifdef AXIS_STIM_GAP_EN
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  logic [31:0]           lo32;
  logic [31:0]           bit_idx;
  logic [DATA_WIDTH-1:0] rep;

  // Pattern select; upper lanes mirror the low 32 bits except walking-one
  always_comb begin
    bit_idx = 32'(beat_q) % 32'(DATA_WIDTH);
    case (mode_q)
      2'd1:    lo32 = lfsr_q;
      2'd3:    lo32 = {8'(dest_q), 8'(pkt_q), 16'(beat_q)};
      default: lo32 = gbeat_q;
    endcase
    rep = '0;
    for (int i = 0; i < DATA_WIDTH; i++) rep[i] = lo32[i % 32];
    if (mode_q == 2'd2) M_AXIS_tdata = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << bit_idx;
    else                M_AXIS_tdata = rep;
  end

  assign M_AXIS_tdest = dest_q;
  assign M_AXIS_tkeep = '1;
  assign M_AXIS_tlast = M_AXIS_tvalid && is_last;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);

endmodule
